// File: rtl/fft_ram_pkg.sv
// Shared constants for the FFT working-RAM arbiter and the FFT address generator.
package fft_ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a registered priority pointer and a lock-owner override.
module rr_arb2
  import fft_ram_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [1:0] lock_own,
  output logic       gnt_a,
  output logic       gnt_b
);

  logic ptr_r;  // 0: A has priority, 1: B has priority

  // Grant selection: lock owner first, then single requester, then pointer
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (RST) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else begin
      case (lock_own)
        OWN_A:   gnt_a = req_a;
        OWN_B:   gnt_b = req_b;
        default: begin
          if (req_a && req_b) begin
            gnt_a = ~ptr_r;
            gnt_b = ptr_r;
          end else begin
            gnt_a = req_a;
            gnt_b = req_b;
          end
        end
      endcase
    end
  end

  // Priority pointer moves to the port that was not granted
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_r <= 1'b0;
    end else if (gnt_a) begin
      ptr_r <= 1'b1;
    end else if (gnt_b) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/fft_ram_arbiter.sv
// Shares one 256x16 block RAM between the FFT butterfly engine (A) and the sample loader (B),
// with round-robin arbitration, a bounded lock and read-data routing.
module fft_ram_arbiter
  import fft_ram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int                LOCK_W   = $clog2(LOCK_MAX + 1);
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_MAX);

  logic [1:0]        own_r, own_nxt_s, gnt_own_s;
  logic [LOCK_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic              win_s, sel_we_s, sel_lock_s, own_req_s;
  logic [ADDR_W-1:0] sel_addr_s, raddr_r, waddr_r;
  logic [DATA_W-1:0] sel_wdata_s, wdata_r;
  logic              rd_pend_r, rd_tag_r;

  rr_arb2 u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req_a    (a_req),
    .req_b    (b_req),
    .lock_own (own_r),
    .gnt_a    (a_gnt),
    .gnt_b    (b_gnt)
  );

  // Winner request mux
  always_comb begin
    win_s       = a_gnt | b_gnt;
    sel_we_s    = a_we;
    sel_lock_s  = a_lock;
    sel_addr_s  = a_addr;
    sel_wdata_s = a_wdata;
    gnt_own_s   = OWN_A;
    if (b_gnt) begin
      sel_we_s    = b_we;
      sel_lock_s  = b_lock;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
      gnt_own_s   = OWN_B;
    end else begin
      gnt_own_s   = OWN_A;
    end
  end

  // RAM pins are driven in the grant cycle; addresses and data hold when idle
  assign ram_re    = win_s & ~sel_we_s;
  assign ram_we    = win_s & sel_we_s;
  assign ram_raddr = ram_re ? sel_addr_s : raddr_r;
  assign ram_waddr = ram_we ? sel_addr_s : waddr_r;
  assign ram_wdata = ram_we ? sel_wdata_s : wdata_r;

  // Last-driven RAM address/data holders
  always_ff @(posedge CLK) begin
    if (RST) begin
      raddr_r <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      raddr_r <= ram_raddr;
      waddr_r <= ram_waddr;
      wdata_r <= ram_wdata;
    end
  end

  // Lock ownership: take, extend, or release the lock
  always_comb begin
    own_nxt_s = own_r;
    cnt_nxt_s = cnt_r;
    cnt_inc_s = (own_r == gnt_own_s) ? (cnt_r + LOCK_W'(1)) : LOCK_W'(1);
    case (own_r)
      OWN_A:   own_req_s = a_req;
      OWN_B:   own_req_s = b_req;
      default: own_req_s = 1'b1;
    endcase
    if (!own_req_s) begin
      own_nxt_s = OWN_NONE;
      cnt_nxt_s = '0;
    end else if (win_s && sel_lock_s && (cnt_inc_s < LOCK_LIM)) begin
      own_nxt_s = gnt_own_s;
      cnt_nxt_s = cnt_inc_s;
    end else if (win_s) begin
      // unlocked grant or limit reached; the pointer already favours the other port
      own_nxt_s = OWN_NONE;
      cnt_nxt_s = '0;
    end else begin
      own_nxt_s = own_r;
      cnt_nxt_s = cnt_r;
    end
  end

  // Lock owner and counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      own_r <= OWN_NONE;
      cnt_r <= '0;
    end else begin
      own_r <= own_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Read-latency pipeline: pending flag plus destination tag (1 = B)
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend_r <= 1'b0;
      rd_tag_r  <= 1'b0;
    end else begin
      rd_pend_r <= ram_re;
      rd_tag_r  <= ram_re ? b_gnt : rd_tag_r;
    end
  end

  assign a_rvalid = rd_pend_r & ~rd_tag_r;
  assign b_rvalid = rd_pend_r & rd_tag_r;
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_fft_ram_arbiter.sv
// Table-driven bench for fft_ram_arbiter with a behavioural 256x16 registered-read RAM.
module tb_fft_ram_arbiter;

  logic        CLK, RST;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [7:0]  ram_raddr, ram_waddr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        ram_re, ram_we;
  logic [15:0] mem [0:255];
  int          total, bad;

  fft_ram_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // RAM model: preloaded with mem[i] = i+1 while in reset, registered read
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i + 1);
    end else begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_raddr];
    end
  end

  typedef struct {
    logic ar, aw, al; logic [7:0] aa; logic [15:0] ad;
    logic br, bw, bl; logic [7:0] ba; logic [15:0] bd;
    logic eag, ebg, earv, ebrv; logic [15:0] edat;
  } vec_t;

  vec_t tbl [0:33];

  function automatic vec_t mk(input logic ar, aw, al, input logic [7:0] aa, input logic [15:0] ad,
                              input logic br, bw, bl, input logic [7:0] ba, input logic [15:0] bd,
                              input logic eag, ebg, earv, ebrv, input logic [15:0] edat);
    vec_t v;
    v.ar = ar; v.aw = aw; v.al = al; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.bl = bl; v.ba = ba; v.bd = bd;
    v.eag = eag; v.ebg = ebg; v.earv = earv; v.ebrv = ebrv; v.edat = edat;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_req = v.ar; a_we = v.aw; a_lock = v.al; a_addr = v.aa; a_wdata = v.ad;
    b_req = v.br; b_we = v.bw; b_lock = v.bl; b_addr = v.ba; b_wdata = v.bd;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, " a_gnt"}, a_gnt, 1'b0);
    chk1({tag, " b_gnt"}, b_gnt, 1'b0);
    chk1({tag, " ram_re"}, ram_re, 1'b0);
    chk1({tag, " ram_we"}, ram_we, 1'b0);
    chk1({tag, " a_rvalid"}, a_rvalid, 1'b0);
    chk1({tag, " b_rvalid"}, b_rvalid, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // contention from reset: A reads 0x0A (0x000B), B reads 0x14 (0x0015)
    tbl[0]  = mk(1'b1,1'b0,1'b0,8'h0A,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    tbl[1]  = mk(1'b1,1'b0,1'b0,8'h0A,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b1,1'b0,16'h000B);
    tbl[2]  = mk(1'b1,1'b0,1'b0,8'h0A,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b0,1'b1,16'h0015);
    tbl[3]  = mk(1'b1,1'b0,1'b0,8'h0A,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b1,1'b0,16'h000B);
    tbl[4]  = mk(1'b1,1'b0,1'b0,8'h0A,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b0,1'b1,16'h0015);
    tbl[5]  = mk(1'b1,1'b0,1'b0,8'h0A,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b1,1'b0,16'h000B);
    tbl[6]  = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b1,16'h0015);
    // single-port read latency
    tbl[7]  = mk(1'b1,1'b0,1'b0,8'h03,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    tbl[8]  = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b1,1'b0,16'h0004);
    // B write then read
    tbl[9]  = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b1,1'b0,8'h80,16'hBEEF, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    tbl[10] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,8'h80,16'h0, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    tbl[11] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b1,16'hBEEF);
    // A write contends with B read of the same word
    tbl[12] = mk(1'b1,1'b1,1'b0,8'h05,16'h1234, 1'b1,1'b0,1'b0,8'h05,16'h0, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    tbl[13] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,8'h05,16'h0, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    tbl[14] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b1,16'h1234);
    // lock taken then released by an unlocked grant
    tbl[15] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    tbl[16] = mk(1'b1,1'b0,1'b0,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b1,1'b0,16'h0004);
    tbl[17] = mk(1'b1,1'b0,1'b0,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b1,1'b0,16'h0004);
    tbl[18] = mk(1'b1,1'b0,1'b0,8'h03,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,1'b1,16'h0015);
    tbl[19] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b1,1'b0,16'h0004);
    // B locks then drops req: A blocked one cycle, then granted
    tbl[20] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b1,8'h14,16'h0, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    tbl[21] = mk(1'b1,1'b0,1'b0,8'h03,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b1,16'h0015);
    tbl[22] = mk(1'b1,1'b0,1'b0,8'h03,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,1'b0,16'h0000);
    tbl[23] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b1,1'b0,16'h0004);
    // bounded lock: A holds 4 grants, B wins the 5th
    tbl[24] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    tbl[25] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b0,1'b1,16'h0015);
    tbl[26] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b1,1'b0,16'h0004);
    tbl[27] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b1,1'b0,16'h0004);
    tbl[28] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b1,1'b0,16'h0004);
    tbl[29] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b1,1'b0,16'h0004);
    tbl[30] = mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b1,1'b0,1'b0,1'b1,16'h0015);
    tbl[31] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b1,1'b0,16'h0004);
    tbl[32] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b1,1'b0,1'b0,16'h0000);
    tbl[33] = mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b1,16'h0015);

    // reset with both ports requesting: nothing may be granted
    RST = 1'b1;
    drive(mk(1'b1,1'b1,1'b0,8'h01,16'h5555, 1'b1,1'b0,1'b0,8'h02,16'h0, 1'b0,1'b0,1'b0,1'b0,16'h0));
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      chk_quiet($sformatf("rst%0d", c));
    end
    @(negedge CLK);
    RST = 1'b0;
    drive(mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b0,16'h0));
    #1;
    chk_quiet("idle");

    for (int i = 0; i < 34; i++) begin
      @(negedge CLK);
      drive(tbl[i]);
      #1;
      chk1($sformatf("r%0d a_gnt", i), a_gnt, tbl[i].eag);
      chk1($sformatf("r%0d b_gnt", i), b_gnt, tbl[i].ebg);
      chk1($sformatf("r%0d a_rvalid", i), a_rvalid, tbl[i].earv);
      chk1($sformatf("r%0d b_rvalid", i), b_rvalid, tbl[i].ebrv);
      chk1($sformatf("r%0d ram_re", i), ram_re, (tbl[i].eag && !tbl[i].aw) || (tbl[i].ebg && !tbl[i].bw));
      chk1($sformatf("r%0d ram_we", i), ram_we, (tbl[i].eag && tbl[i].aw) || (tbl[i].ebg && tbl[i].bw));
      if (tbl[i].earv) chk16($sformatf("r%0d a_rdata", i), a_rdata, tbl[i].edat);
      if (tbl[i].ebrv) chk16($sformatf("r%0d b_rdata", i), b_rdata, tbl[i].edat);
    end

    // idle cycle: RAM address/data outputs hold their last driven values
    chk16("hold raddr", {8'h00, ram_raddr}, 16'h0014);
    chk16("hold waddr", {8'h00, ram_waddr}, 16'h0005);
    chk16("hold wdata", ram_wdata, 16'h1234);

    // reset mid-read while A holds the lock
    @(negedge CLK);
    drive(mk(1'b1,1'b0,1'b1,8'h03,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b0,16'h0));
    #1;
    chk1("mr lock gnt", a_gnt, 1'b1);
    @(negedge CLK);
    #1;
    chk1("mr a_gnt pre", a_gnt, 1'b1);
    chk1("mr a_rvalid pre", a_rvalid, 1'b1);
    chk16("mr a_rdata pre", a_rdata, 16'h0004);
    RST = 1'b1;
    #1;
    chk1("mr a_gnt rst", a_gnt, 1'b0);
    chk1("mr ram_re rst", ram_re, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    drive(mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b1,1'b0,1'b0,8'h14,16'h0, 1'b0,1'b0,1'b0,1'b0,16'h0));
    #1;
    chk1("mr a_rvalid post", a_rvalid, 1'b0);
    chk1("mr b_rvalid post", b_rvalid, 1'b0);
    chk1("mr lock dropped", b_gnt, 1'b1);
    a_req = 1'b1;
    #1;
    chk1("mr ptr a_gnt", a_gnt, 1'b1);
    chk1("mr ptr b_gnt", b_gnt, 1'b0);
    @(negedge CLK);
    drive(mk(1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,8'h00,16'h0, 1'b0,1'b0,1'b0,1'b0,16'h0));
    @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
